// File: rtl/dff_share_arb.sv
// Four-requester round-robin arbiter that owns a single shared WIDTH-bit register.
// Optional per-grant hold limit is compiled in with `define DFF_SHARE_ARB_TIMEOUT_EN.
module dff_share_arb #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   wr_data,
    output logic [3:0]           gnt,
    output logic [1:0]           owner,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     q_not,
    output logic                 valid,
    output logic                 o_dbg_state
);

    // Handshake: a requester holds req[i] for as long as it wants the register;
    // gnt[i] (registered) marks the cycles in which its wr_data word is loaded on
    // the next edge. Dropping req[i] releases ownership after one edge.

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("dff_share_arb: MAX_HOLD must be in 1..15");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_gnt;
    logic [3:0]         w_gnt_nxt;
    logic [1:0]         r_owner;
    logic [1:0]         w_owner_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         w_ptr_nxt;
    logic [1:0]         w_winner;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [WIDTH-1:0]   w_data [4];

`ifdef DFF_SHARE_ARB_TIMEOUT_EN
    logic [3:0]         r_hold_cnt;
    logic [3:0]         w_hold_cnt_nxt;
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_data[gi] = wr_data[gi*WIDTH +: WIDTH];
    end

    // Search starts just after the last winner, so the last winner has lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_winner = rr_pick(req, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_q_nxt     = r_q;
        w_valid_nxt = r_valid;
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
        w_hold_cnt_nxt = r_hold_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_OWNED;
                    w_gnt_nxt   = 4'b0001 << w_winner;
                    w_owner_nxt = w_winner;
                    w_ptr_nxt   = w_winner;
                    w_q_nxt     = w_data[w_winner];
                    w_valid_nxt = 1'b1;
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
                    w_hold_cnt_nxt = 4'd1;
`endif
                end
            end
            ST_OWNED: begin
                if (!req[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                end
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
                else if (r_hold_cnt == 4'(MAX_HOLD)) begin
                    // Forced release skips the load so the next owner sees an untouched value.
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                end
`endif
                else begin
                    w_q_nxt = w_data[r_owner];
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
                    if (r_hold_cnt != 4'hF) begin
                        w_hold_cnt_nxt = r_hold_cnt + 4'd1;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_owner <= 2'd0;
            r_ptr   <= 2'd3;
            r_q     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_q     <= w_q_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef DFF_SHARE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= 4'd0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end
`endif

    assign gnt         = r_gnt;
    assign owner       = r_owner;
    assign q           = r_q;
    assign q_not       = ~r_q;
    assign valid       = r_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed-vector bench for dff_share_arb: reset, round-robin order, data path,
// hold/timeout behaviour and mid-grant reset.
module tb_dff_share_arb;

    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [3:0]           req = 4'b0000;
    logic [4*WIDTH-1:0]   wr_data = '0;
    logic [3:0]           gnt;
    logic [1:0]           owner;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     q_not;
    logic                 valid;
    logic                 o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    dff_share_arb #(.WIDTH(WIDTH), .MAX_HOLD(4)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .wr_data     (wr_data),
        .gnt         (gnt),
        .owner       (owner),
        .q           (q),
        .q_not       (q_not),
        .valid       (valid),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [WIDTH-1:0] v);
        wr_data[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        logic [1:0] exp_owner;

        // Asynchronous reset before any clock edge
        #1;
        reset = 1'b0;
        req   = 4'($urandom_range(0, 15));
        #2;
        check("rst_gnt",   32'(gnt),   32'h0);
        check("rst_q",     32'(q),     32'h00);
        check("rst_q_not", 32'(q_not), 32'hFF);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_state", 32'(o_dbg_state), 32'h0);

        step();
        req   = 4'b0000;
        reset = 1'b1;
        step();
        check("idle_gnt",   32'(gnt),   32'h0);
        check("idle_valid", 32'(valid), 32'h0);

        // All four requesting: expect 0,1,2,3,0 with an IDLE gap between grants
        for (int i = 0; i < 4; i++) set_wd(i, WIDTH'(8'hA0 + i));
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        req = 4'b1111;
        step();
        while (exp_q.size() != 0) begin
            exp_owner = exp_q.pop_front();
            check("rr_gnt",   32'(gnt),   32'(4'b0001 << exp_owner));
            check("rr_owner", 32'(owner), 32'(exp_owner));
            check("rr_q",     32'(q),     32'(8'hA0 + exp_owner));
            check("rr_valid", 32'(valid), 32'h1);
            req = 4'b1111 & ~(4'b0001 << exp_owner);
            step();
            check("rr_gap", 32'(gnt), 32'h0);
            req = 4'b1111;
            step();
        end
        check("rr_next_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        check("rr_release", 32'(gnt), 32'h0);

        // Data path through requester 2, non-owner requests ignored
        set_wd(2, 8'h11);
        req = 4'b0100;
        step();
        check("dp_gnt",   32'(gnt),   32'h4);
        check("dp_owner", 32'(owner), 32'h2);
        check("dp_q11",   32'(q),     32'h11);
        set_wd(2, 8'h22);
        step();
        check("dp_q22",   32'(q),     32'h22);
        check("dp_qn22",  32'(q_not), 32'hDD);
        set_wd(2, 8'h33);
        set_wd(0, 8'h5A);
        req = 4'b0111;
        step();
        check("dp_q33",     32'(q),     32'h33);
        check("dp_keep_gnt", 32'(gnt),  32'h4);
        check("dp_keep_own", 32'(owner), 32'h2);
        req = 4'b0000;
        set_wd(2, 8'h99);
        step();
        check("dp_rel_gnt", 32'(gnt), 32'h0);
        check("dp_rel_q",   32'(q),   32'h33);
        step();
        check("dp_idle_q",     32'(q),     32'h33);
        check("dp_idle_owner", 32'(owner), 32'h2);
        check("dp_idle_valid", 32'(valid), 32'h1);
        check("dp_idle_state", 32'(o_dbg_state), 32'h0);

`ifdef DFF_SHARE_ARB_TIMEOUT_EN
        // Hold limit of 4 cycles alternates requesters 0 and 1
        req = 4'b0011;
        step();
        check("to_gnt0_first", 32'(gnt), 32'h1);
        check("to_q0",         32'(q),   32'h5A);
        for (int c = 0; c < 3; c++) begin
            step();
            check("to_gnt0", 32'(gnt), 32'h1);
        end
        step();
        check("to_gap0", 32'(gnt), 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("to_gnt1", 32'(gnt), 32'h2);
        end
        step();
        check("to_gap1", 32'(gnt), 32'h0);
        step();
        check("to_gnt0_again", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        check("to_release", 32'(gnt), 32'h0);
`else
        // No hold limit: requester 0 keeps the grant
        req = 4'b0011;
        step();
        check("hold_q0", 32'(q), 32'h5A);
        check("hold_gnt_first", 32'(gnt), 32'h1);
        for (int c = 0; c < 19; c++) begin
            step();
            check("hold_gnt", 32'(gnt), 32'h1);
        end
        req = 4'b0000;
        step();
        check("hold_release", 32'(gnt), 32'h0);
`endif

        // Reset in the middle of a grant to requester 2
        set_wd(0, 8'h77);
        set_wd(2, 8'h66);
        req = 4'b0100;
        step();
        check("mr_gnt_pre", 32'(gnt), 32'h4);
        check("mr_q_pre",   32'(q),   32'h66);
        #2;
        reset = 1'b0;
        #1;
        check("mr_gnt",   32'(gnt),   32'h0);
        check("mr_q",     32'(q),     32'h00);
        check("mr_q_not", 32'(q_not), 32'hFF);
        check("mr_valid", 32'(valid), 32'h0);
        check("mr_owner", 32'(owner), 32'h0);
        req = 4'b0101;
        step();
        check("mr_held_gnt", 32'(gnt), 32'h0);
        reset = 1'b1;
        step();
        check("mr_first_gnt",   32'(gnt),   32'h1);
        check("mr_first_owner", 32'(owner), 32'h0);
        check("mr_first_q",     32'(q),     32'h77);
        check("mr_first_valid", 32'(valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dff_share_arb.md
DFF_SHARE_ARB -- requirements
Module: dff_share_arb

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the shared register and of each requester data word.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive owned cycles per grant when timeout is compiled in; legal range 1..15.
REQ-003 clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 req  input  4: per-requester request, bit i = requester i.
REQ-006 wr_data  input  4*WIDTH: packed requester data; requester i drives bits [i*WIDTH +: WIDTH].
REQ-007 gnt  output  4: registered one-hot grant, all-zero when no owner.
REQ-008 owner  output  2: registered index of the current or last owner.
REQ-009 q  output  WIDTH: the shared register contents.
REQ-010 q_not  output  WIDTH: combinational bitwise inverse of q.
REQ-011 valid  output  1: high once q has been loaded at least once since reset.

Function
REQ-012 FSM SHALL have exactly two states: IDLE (gnt = 0) and OWNED (gnt one-hot).
REQ-013 IDLE, req = 0: SHALL stay in IDLE; q, owner and ptr hold.
REQ-014 IDLE, req != 0: next edge SHALL pick winner w by round-robin, set gnt = 1<<w, owner = w, ptr = w, q = wr_data[w], valid = 1, hold_cnt = 1, and enter OWNED.
REQ-015 Round-robin search order SHALL be ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set req bit wins.
REQ-016 OWNED, req[owner] = 1, not timed out: each edge SHALL load q = wr_data[owner] and increment hold_cnt (saturating at 15).
REQ-017 OWNED, req[owner] = 0: next edge SHALL clear gnt, return to IDLE, and hold q at its last value with no load that cycle.
REQ-018 Release SHALL always pass through one IDLE cycle, so the minimum gap between two grants is one cycle with gnt = 0.
REQ-019 Requests from non-owners during OWNED SHALL be ignored and have no effect on q, owner or ptr.
REQ-020 Changes to req[owner] and wr_data SHALL be sampled only at the clock edge, giving one-cycle latency from input to q.
REQ-021 q_not SHALL equal ~q at all times, including during reset.

Reset
REQ-022 reset low SHALL immediately, without waiting for clk, force: state = IDLE, gnt = 0, owner = 0, q = 0 (so q_not = all ones), valid = 0, hold_cnt = 0, ptr = 3.
REQ-023 A reset assertion during OWNED SHALL abort the grant; the first grant after deassertion follows REQ-015 with ptr = 3, so requester 0 has top priority.
REQ-024 The first rising clk edge with reset high SHALL be a normal functional edge.

Configuration
REQ-025 Macro DFF_SHARE_ARB_TIMEOUT_EN: when defined, an edge in OWNED with hold_cnt = MAX_HOLD and req[owner] = 1 SHALL clear gnt, enter IDLE, and skip the q load for that edge.
REQ-026 With DFF_SHARE_ARB_TIMEOUT_EN defined and no other requester, the timed-out requester SHALL be re-granted after one IDLE cycle.
REQ-027 With DFF_SHARE_ARB_TIMEOUT_EN undefined, hold_cnt and the timeout logic SHALL be absent, and an owner SHALL keep the grant for as long as it holds req.

Verification
REQ-028 Reset check: reset = 0 with random req -> gnt = 0, q = 0x00, q_not = 0xFF, valid = 0, asynchronously, with no clk edge.
REQ-029 Simultaneous request: req = 4'b1111 after reset -> grant sequence 0, 1, 2, 3, 0, where each requester drops req one cycle after its grant, with one IDLE cycle between grants.
REQ-030 Data path: requester 2 granted, wr_data[2] goes 0x11, 0x22, 0x33 on successive cycles -> q follows with one-cycle latency; after req[2] drops, q holds 0x33.
REQ-031 Timeout (macro defined, MAX_HOLD = 4): req = 4'b0011 held constant -> gnt0 for 4 cycles, 1 IDLE cycle, gnt1 for 4 cycles, then gnt0 again.
REQ-032 No timeout (macro undefined): req = 4'b0011 held for 20 cycles -> gnt stays 4'b0001 throughout.
REQ-033 Mid-operation reset: reset pulsed low during gnt = 4'b0100 -> gnt = 0 and q = 0 immediately; with req = 4'b0101 after release, requester 0 is granted first.
